// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if -- groups the fetch controller's bus signals.
//   PC register side : pc (to ctrl), pcwr (from ctrl), flush (to ctrl)
//   imem side        : imem_req/imem_addr (from ctrl), imem_gnt/imem_rvalid/imem_rdata (to ctrl)
//   decode side      : id_valid/id_instr/id_pc (from ctrl), id_ready (to ctrl)
// master = the fetch controller, slave = its environment.
interface if_fetch_ctrl_if;
    logic [31:0] pc;
    logic        pcwr;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output pcwr, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output pc, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  pcwr, imem_req, imem_addr, id_valid, id_instr, id_pc
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl -- instruction-fetch controller.
// Issues one imem read at a time at the current pc, pulses pcwr when the read
// is granted (or on a redirect), and buffers returned {instr, pc} pairs in a
// DEPTH-entry FIFO toward decode. A flush empties the FIFO and marks any
// in-flight read to be dropped when it returns.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : if_fetch_ctrl_if.master (pc/pcwr/flush, imem req/gnt/rvalid, id handshake)
module if_fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fentry_t;

    state_t        state, state_nxt;
    fentry_t       mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [31:0]   req_pc;
    logic          outstanding, can_issue, grant, push, pop;

    // Buffered plus outstanding may never exceed DEPTH, so a response always
    // has a slot waiting for it. rst gates the request so nothing leaks out
    // while reset is held.
    assign outstanding = (state != IDLE);
    assign can_issue   = rst && !bus.flush &&
                         (state == IDLE || (state == WAIT && bus.imem_rvalid)) &&
                         ((count + CW'(outstanding)) < DEPTH_C);
    assign grant       = can_issue && bus.imem_gnt;
    assign push        = (state == WAIT) && bus.imem_rvalid && !bus.flush;
    assign pop         = (count != '0) && bus.id_ready && !bus.flush;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; a grant while retiring a response keeps us in WAIT
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (grant) state_nxt = WAIT;
            WAIT: begin
                if (grant)                              state_nxt = WAIT;
                else if (bus.flush && !bus.imem_rvalid) state_nxt = DROP;
                else if (bus.imem_rvalid)               state_nxt = IDLE;
            end
            DROP: if (bus.imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.imem_req  = can_issue;
        bus.imem_addr = bus.pc;
        bus.pcwr      = rst && (grant || bus.flush);
        bus.id_valid  = (count != '0);
        bus.id_instr  = mem[rptr].instr;
        bus.id_pc     = mem[rptr].pc;
    end

    // PC of the outstanding request, paired with its data on return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       req_pc <= '0;
        else if (grant) req_pc <= bus.pc;
    end

    // FIFO; flush wins over a same-cycle pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{instr: bus.imem_rdata, pc: req_pc};
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && count == DEPTH_C));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl -- randomized bench for if_fetch_ctrl.
// The bench plays PC register and instruction memory. Each accepted response
// pushes its expected {instr, pc} onto a queue; a separate monitor pops and
// compares whenever decode takes the head.
module tb_if_fetch_ctrl;
    localparam int DEPTH = 2;
    localparam logic [31:0] XORM = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_fetch_ctrl_if bus();
    if_fetch_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    // stimulus knobs
    int gnt_pct, rdy_pct, flush_pct, lat_min, lat_max;
    bit force_flush = 0;
    logic [31:0] forced_tgt;

    // PC register / memory model
    logic [31:0] cur_pc, next_pc, flush_tgt;
    bit          pending, pend_drop;
    logic [31:0] pend_addr;
    int          pend_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle();
        bit   exp_req, grant_m;
        @(posedge clk);
        #1;
        cur_pc       = next_pc;
        bus.pc       = cur_pc;
        bus.id_ready = ($urandom_range(99) < rdy_pct);
        bus.imem_gnt = ($urandom_range(99) < gnt_pct);
        if (force_flush) begin
            bus.flush   = 1'b1;
            flush_tgt   = forced_tgt;
            force_flush = 0;
        end else begin
            bus.flush = ($urandom_range(99) < flush_pct);
            flush_tgt = 32'h4000 + ($urandom_range(0, 1023) << 2);
        end
        if (pending && pend_cnt > 0) pend_cnt--;
        bus.imem_rvalid = pending && (pend_cnt == 0);
        bus.imem_rdata  = bus.imem_rvalid ? (pend_addr ^ XORM) : $urandom;

        @(negedge clk);
        // one read in flight at most; a dropped read blocks issue until it returns
        exp_req = !bus.flush &&
                  (!pending || (bus.imem_rvalid && !pend_drop)) &&
                  (expq.size() + int'(pending) < DEPTH);
        grant_m = exp_req && bus.imem_gnt;
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (bus.imem_req) chk("imem_addr", bus.imem_addr, cur_pc);
        chk("pcwr", {31'd0, bus.pcwr}, {31'd0, grant_m || bus.flush});
        chk("id_valid", {31'd0, bus.id_valid}, {31'd0, expq.size() != 0});

        if (bus.flush) expq.delete();
        if (bus.imem_rvalid) begin
            if (!pend_drop && !bus.flush)
                expq.push_back('{instr: pend_addr ^ XORM, pc: pend_addr});
            pending   = 0;
            pend_drop = 0;
        end else if (pending && bus.flush) begin
            pend_drop = 1;
        end
        if (grant_m) begin
            pending   = 1;
            pend_drop = 0;
            pend_addr = cur_pc;
            pend_cnt  = $urandom_range(lat_max, lat_min);
        end
        next_pc = bus.flush ? flush_tgt : (grant_m ? cur_pc + 32'd4 : cur_pc);
    endtask

    task automatic run(input int n, input int g, input int r, input int f,
                       input int lmin, input int lmax);
        gnt_pct = g; rdy_pct = r; flush_pct = f; lat_min = lmin; lat_max = lmax;
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    // Monitor: runs just after the driver's negedge evaluation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.id_valid && bus.id_ready && !bus.flush) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL id_pop: unexpected entry pc=%h at %0t", bus.id_pc, $time);
                end else begin
                    e = expq.pop_front();
                    chk("id_pc", bus.id_pc, e.pc);
                    chk("id_instr", bus.id_instr, e.instr);
                end
            end
        end
    end

    initial begin
        int waited;
        bus.pc = 32'h3000; bus.flush = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0;
        bus.imem_rdata = 0; bus.id_ready = 0;
        cur_pc = 32'h3000; next_pc = 32'h3000; flush_tgt = 0;
        pending = 0; pend_drop = 0; pend_addr = 0; pend_cnt = 0;
        forced_tgt = 32'h3400;

        repeat (2) @(negedge clk);
        bus.imem_gnt = 1;
        #1;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pcwr", {31'd0, bus.pcwr}, 32'd0);
        chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_id_pc", bus.id_pc, 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'd0);
        bus.imem_gnt = 0;
        @(posedge clk);
        #1 rst = 1'b1;

        // streaming, 1-cycle latency
        run(20, 100, 100, 0, 1, 1);
        // backpressure then drain
        run(8, 100, 0, 0, 1, 1);
        chk("bp_req_idle", {31'd0, bus.imem_req}, 32'd0);
        chk("bp_head_valid", {31'd0, bus.id_valid}, 32'd1);
        run(10, 100, 100, 0, 1, 1);
        // grant withheld
        run(6, 0, 100, 0, 1, 1);
        // directed flush while a 3-cycle read is in flight
        gnt_pct = 100; rdy_pct = 100; flush_pct = 0; lat_min = 3; lat_max = 3;
        waited = 0;
        while (!pending && waited < 10) begin
            drive_cycle();
            waited++;
        end
        chk("flush_setup_pending", {31'd0, pending}, 32'd1);
        forced_tgt  = 32'h3400;
        force_flush = 1;
        run(12, 100, 100, 0, 3, 3);
        // randomized mix
        run(2000, 70, 60, 5, 1, 4);
        // drain
        run(12, 0, 100, 0, 1, 4);
        chk("drain_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("drain_queue", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller; the consumer side of the PC register.
- Issues instruction-memory reads at the current pc and drives PCWr back to the PC register when a fetch is accepted, so the PC advances only when a read is actually granted.
- Buffers returned instructions with their PC in a small FIFO toward the IF/ID stage.
- Handles branch/jump redirect (flush) by discarding buffered and in-flight fetches.

Parameters:
- DEPTH, 2, fetch FIFO entries (power of two, ≥2); bounds buffered plus outstanding fetches.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pc  input  32  current PC from the PC register.
- pcwr  output  1  PC write enable to the PC register (loads NPC).
- flush  input  1  redirect; NPC already selects the target this cycle.
- imem_req  output  1  instruction read request.
- imem_addr  output  32  read address, equal to pc.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; responses return in order, ≥1 cycle after grant.
- imem_rdata  input  32  instruction word.
- id_valid  output  1  FIFO head valid toward decode.
- id_ready  input  1  decode accepts the head.
- id_instr  output  32  head instruction.
- id_pc  output  32  head instruction's PC.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, FIFO count=0, pointers=0, id_valid=0, imem_req=0, pcwr=0. id_instr/id_pc=0.
- At most one outstanding request. outstanding=1 in states WAIT and DROP.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its data will be kept.
  - DROP: one request outstanding; its data will be discarded.
- Issue condition, combinational on registered state: can_issue = !flush & (state==IDLE | (state==WAIT & imem_rvalid)) & (count + outstanding < DEPTH).
  - imem_req = can_issue.
  - imem_addr = pc.
- pcwr = (imem_req & imem_gnt) | flush, combinational. A 0→1 transition of pcwr is never registered.
- On imem_req & imem_gnt: latch req_pc = pc; next state WAIT. This holds even when leaving WAIT on an rvalid in the same cycle, giving back-to-back fetches.
- WAIT & imem_rvalid & !flush:
  - push {imem_rdata, req_pc} into the FIFO;
  - next state IDLE unless a new grant occurs that cycle.
- Pop: id_valid & id_ready advances the read pointer.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the issue rule. A push with count==DEPTH is an assertion failure.
- FIFO outputs:
  - id_valid = (count != 0);
  - id_instr/id_pc = head entry (registered storage, no bypass; push-to-id_valid latency is 1 cycle).
  - Pointers wrap modulo DEPTH.
- flush (highest priority):
  - FIFO cleared (count=0, pointers reset) at the clock edge; a same-cycle pop is ignored.
  - No request is issued that cycle; pcwr=1.
  - WAIT & !imem_rvalid → DROP.
  - WAIT & imem_rvalid → IDLE; data discarded.
  - DROP & !imem_rvalid → DROP.
  - DROP & imem_rvalid → IDLE.
  - IDLE → IDLE.
- DROP & imem_rvalid & !flush → IDLE; data discarded; no issue that cycle (can_issue excludes DROP).
- Fetch latency: req granted at cycle T with rvalid at T+k → id_valid at T+k+1.
- imem_req may be held while imem_gnt=0. pc is stable meanwhile because pcwr=0.
- Asserting rst mid-operation abandons any in-flight response. The environment must reset the memory model too.

Test Plan:
- Reset then release, gnt=1, rvalid 1 cycle after gnt, id_ready=1, rdata=addr^0xFFFF_0000 → first imem_addr=0x00003000 with pcwr pulse; id_pc sequence 0x3000, 0x3004, 0x3008, …, each paired with the matching id_instr.
- Back-to-back: rvalid the cycle after each grant, DEPTH=2, id_ready=1 → a new request is issued in the same cycle as each rvalid; no bubble after the first fetch.
- Backpressure: id_ready=0 → exactly 2 entries (0x3000, 0x3004) buffered, imem_req stays 0, pc frozen. id_ready=1 → both drain in order, then fetching resumes at 0x3008.
- Flush while WAIT, rvalid 3 cycles later, next pc=0x3400 → pcwr=1 on the flush cycle; FIFO empties; the stale response is not delivered; next imem_addr=0x3400; first id_pc after flush is 0x3400.
- Flush in the same cycle as rvalid and a pop → nothing pushed, count=0, state IDLE, no request that cycle.
- imem_gnt held 0 for 5 cycles → imem_req=1 steady, imem_addr constant, pcwr=0 throughout.
